writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/rv_pkg.sv | 25 ++
 rtl/wb_skid_fifo.sv | 49 ++++
 rtl/writeback_unit.sv | 115 +++++++++++
 tb/tb_writeback_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ============================================================================
// Module : rv_pkg
// Brief  : Shared load-type encodings and the writeback entry record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_skid_fifo.sv
// ============================================================================
// Module : wb_skid_fifo
// Brief  : Two-entry in-order FIFO holding ALU results awaiting writeback.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_skid_fifo
  import rv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push,
  input  wb_entry_t i_push_entry,
  input  logic      i_pop,
  output wb_entry_t o_head,
  output logic [1:0] o_count
);

  wb_entry_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;

  // Storage needs no reset: count and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// Module : writeback_unit
// Brief  : Arbitrates load returns and ALU results onto one register-file port.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_unit
  import rv_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [width-1:0] alu_data,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [width-1:0] mem_data,
  input  logic [2:0]       mem_funct3,
  input  logic [1:0]       mem_offset,
  output logic             rf_en,
  output logic [4:0]       write_addr,
  output logic [width-1:0] write_data
);

  wb_entry_t        w_head;
  wb_entry_t        w_alu_entry;
  wb_entry_t        w_sel;
  logic [1:0]       w_count;
  logic             w_alu_acc;
  logic             w_sel_vld;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [width-1:0] w_load;

  wb_skid_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_entry (w_alu_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  // Readiness depends only on the stored count, never on this cycle's load.
  assign alu_ready = (w_count < 2'd2);
  assign w_alu_acc = alu_valid & alu_ready & ~rst;

  always_comb begin
    w_alu_entry      = '0;
    w_alu_entry.rd   = alu_rd;
    w_alu_entry.data = XLEN'(alu_data);
  end

  assign w_byte = mem_data[{mem_offset, 3'b000} +: 8];
  assign w_half = mem_data[{mem_offset[1], 4'b0000} +: 16];

  always_comb begin
    w_load = mem_data;
    case (mem_funct3)
      F3_LB:   w_load = {{(width-8){w_byte[7]}}, w_byte};
      F3_LH:   w_load = {{(width-16){w_half[15]}}, w_half};
      F3_LBU:  w_load = {{(width-8){1'b0}}, w_byte};
      F3_LHU:  w_load = {{(width-16){1'b0}}, w_half};
      default: w_load = mem_data;
    endcase
  end

  // Loads win outright; queued ALU results drain before any new one bypasses.
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    if (!rst) begin
      if (mem_valid) begin
        w_sel_vld  = 1'b1;
        w_sel.rd   = mem_rd;
        w_sel.data = XLEN'(w_load);
        w_push     = w_alu_acc;
      end else if (w_count != 2'd0) begin
        w_sel_vld = 1'b1;
        w_sel     = w_head;
        w_pop     = 1'b1;
        w_push    = w_alu_acc;
      end else if (w_alu_acc) begin
        w_sel_vld = 1'b1;
        w_sel     = w_alu_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_en      <= 1'b0;
      write_addr <= 5'd0;
      write_data <= '0;
    end else begin
      rf_en <= w_sel_vld && (w_sel.rd != 5'd0);
      if (w_sel_vld) begin
        write_addr <= w_sel.rd;
        write_data <= width'(w_sel.data);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// Module : tb_writeback_unit
// Brief  : Directed and random checks of writeback_unit against a queue model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_offset;
  logic        rf_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;

  int total = 0;
  int bad   = 0;
  wb_entry_t q[$];
  bit last_acc;

  writeback_unit #(.width(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_rd     (mem_rd),
    .mem_data   (mem_data),
    .mem_funct3 (mem_funct3),
    .mem_offset (mem_offset),
    .rf_en      (rf_en),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] f3, input int off);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  // One clock: predict the write produced by the inputs now applied, then compare.
  task automatic tick();
    wb_entry_t nxt;
    wb_entry_t a;
    bit has;
    bit model_ready;
    has = 0;
    nxt = '0;
    last_acc = 0;
    a.rd = alu_rd;
    a.data = alu_data;
    model_ready = (q.size() < 2);
    if (!rst) check("alu_ready", {31'd0, alu_ready}, {31'd0, model_ready});
    if (rst) begin
      q.delete();
    end else begin
      last_acc = alu_valid && model_ready;
      if (mem_valid) begin
        has = 1;
        nxt.rd = mem_rd;
        nxt.data = ref_load(mem_data, mem_funct3, int'(mem_offset));
        if (last_acc) q.push_back(a);
      end else if (q.size() > 0) begin
        has = 1;
        nxt = q.pop_front();
        if (last_acc) q.push_back(a);
      end else if (last_acc) begin
        has = 1;
        nxt = a;
      end
    end
    @(posedge clk);
    #1;
    check("rf_en", {31'd0, rf_en}, {31'd0, (has && nxt.rd != 5'd0)});
    if (has && nxt.rd != 5'd0) begin
      check("write_addr", {27'd0, write_addr}, {27'd0, nxt.rd});
      check("write_data", write_data, nxt.data);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0; mem_funct3 = 0; mem_offset = 0;
  endtask

  initial begin
    logic [4:0] order[$];
    logic [4:0] exp_order[6];
    int k;

    rst = 1;
    idle();
    tick();
    check("reset_addr", {27'd0, write_addr}, 32'd0);
    check("reset_data", write_data, 32'd0);
    check("reset_ready", {31'd0, alu_ready}, 32'd1);
    rst = 0;

    // Single ALU result, memory idle.
    alu_valid = 1; alu_rd = 5; alu_data = 32'h0000_00AA;
    tick();
    check("alu_direct_data", write_data, 32'h0000_00AA);
    idle();
    tick();

    // Load and ALU result collide.
    mem_valid = 1; mem_rd = 3; mem_funct3 = 3'b000; mem_offset = 2; mem_data = 32'h0080_0000;
    alu_valid = 1; alu_rd = 7; alu_data = 32'h11;
    tick();
    check("lb_sext_data", write_data, 32'hFFFF_FF80);
    idle();
    tick();
    check("deferred_alu_addr", {27'd0, write_addr}, 32'd7);

    // Three loads back to back while three ALU results wait their turn.
    k = 0;
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c < 3) begin
        mem_valid = 1; mem_rd = 5'(20 + c); mem_funct3 = 3'b010; mem_data = $urandom;
      end
      if (k < 3) begin
        alu_valid = 1; alu_rd = 5'(10 + k); alu_data = 32'(100 + k);
      end
      tick();
      if (last_acc) k++;
      if (rf_en) order.push_back(write_addr);
    end
    exp_order = '{5'd20, 5'd21, 5'd22, 5'd10, 5'd11, 5'd12};
    check("order_len", order.size(), 32'd6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      check("order", {27'd0, order[i]}, {27'd0, exp_order[i]});

    // Writes to x0 are dropped without stalling.
    idle();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    tick();
    idle();
    mem_valid = 1; mem_rd = 9; mem_funct3 = 3'b101; mem_offset = 2; mem_data = 32'hBEEF_0000;
    tick();
    check("lhu_data", write_data, 32'h0000_BEEF);

    // Fill the FIFO, then reset mid-stream.
    for (int c = 0; c < 2; c++) begin
      idle();
      mem_valid = 1; mem_rd = 5'(1 + c); mem_data = $urandom; mem_funct3 = 3'b010;
      alu_valid = 1; alu_rd = 5'(25 + c); alu_data = $urandom;
      tick();
    end
    rst = 1;
    mem_valid = 1; alu_valid = 1;
    tick();
    rst = 0;
    idle();
    tick();
    check("post_reset_ready", {31'd0, alu_ready}, 32'd1);
    for (int c = 0; c < 3; c++) tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 63) == 0);
      mem_valid  = $urandom_range(0, 1);
      mem_rd     = 5'($urandom);
      mem_data   = $urandom;
      mem_funct3 = 3'($urandom);
      mem_offset = 2'($urandom);
      alu_valid  = ($urandom_range(0, 9) < 7);
      alu_rd     = 5'($urandom);
      alu_data   = $urandom;
      tick();
    end
    rst = 0;
    idle();
    for (int c = 0; c < 3; c++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
